dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single data memory port (datamemory) between two requesters.
- Requester 0 is the core load/store path; requester 1 is the debug/program-loader DMA.
- Round-robin grant, one access at a time, registered memory-side drive, one-cycle read response.
- Misaligned halfword/word accesses are rejected with an error response and never reach memory.

Parameters:
- DM_ADDRESS, 9, width of the byte address into data memory.
- DATA_W, 32, data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- m0_req  input  1  requester 0 access request; held until m0_gnt.
- m0_we  input  1  1 = store, 0 = load.
- m0_addr  input  DM_ADDRESS  byte address.
- m0_wdata  input  DATA_W  store data.
- m0_funct3  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- m0_gnt  output  1  one-cycle pulse: request accepted.
- m0_rvalid  output  1  one-cycle pulse: response (load data or store done) valid.
- m0_rdata  output  DATA_W  load data, valid with m0_rvalid.
- m0_err  output  1  misaligned access, valid with m0_rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_funct3, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as m0_*, for requester 1.
- mem_read  output  1  to datamemory MemRead.
- mem_write  output  1  to datamemory MemWrite.
- mem_a  output  DM_ADDRESS  to datamemory a.
- mem_wd  output  DATA_W  to datamemory wd.
- mem_funct3  output  3  to datamemory Funct3.
- mem_rd  input  DATA_W  from datamemory rd; sampled at the end of the ACCESS cycle.

Behaviour:
- The clock is clk. Reset is asynchronous and active-high on reset.
- Reset values:
  - All outputs 0.
  - State = IDLE.
  - last_grant = 1, so requester 0 wins the first contention.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, pick a winner.
    - Only one requesting: that one wins.
    - Both requesting: the one not equal to last_grant wins.
  - On the winner: latch we/addr/wdata/funct3/id into registers, pulse its gnt in the next cycle, set last_grant = winner.
  - Alignment check at latch time:
    - H/HU is misaligned if addr[0] = 1.
    - W is misaligned if addr[1:0] != 0.
    - B/BU and unlisted funct3 are never misaligned.
  - Aligned: go to ACCESS. Misaligned: go to RESP with err flag set.
- ACCESS (exactly one cycle):
  - Drive mem_read = ~we, mem_write = we, plus mem_a, mem_wd and mem_funct3 from the latched registers.
  - gnt pulses in this cycle.
  - On cycle end, capture mem_rd into the response register; go to RESP.
- RESP (one cycle):
  - Pulse rvalid of the latched id.
  - rdata = captured data for loads, 0 for stores and errors.
  - err = latched flag.
  - mem_read = mem_write = 0.
  - Go to IDLE.
- For an error, gnt pulses in the RESP cycle together with rvalid and err, and memory is never driven.
- Latency:
  - req sampled in IDLE at edge N.
  - gnt and memory access during cycle N+1.
  - rvalid during cycle N+2.
  - Throughput is one access per 3 cycles.
- mem_read and mem_write are never both 1. Memory signals are 0 outside ACCESS.
- rdata and err hold their last value when rvalid = 0. Only rvalid and gnt are defined as pulses.
- A requester must keep req and its fields stable until its gnt.
- A req dropped before gnt is legal only while not selected. Once latched, the access completes regardless of req.
- A requester that wins must deassert req, or it re-competes in the next IDLE. With the other port requesting, it loses next (strict alternation under contention).
- Reset mid-operation: returns to IDLE immediately and drops any in-flight access. No rvalid is issued and last_grant returns to 1.
- Address width is DM_ADDRESS. Ports carry no upper bits, so there is no range check.

Test Plan:
- Single load: m0 requests LW, addr 0x010, with memory model word 0xDEADBEEF. Expect m0_gnt in cycle 1, mem_read = 1 with mem_a = 0x010 in cycle 1, m0_rvalid with m0_rdata = 0xDEADBEEF and m0_err = 0 in cycle 2. m1 outputs stay 0.
- Contention: m0 and m1 both request SW (addr 0x020 data 0x11111111; addr 0x024 data 0x22222222) after reset and hold until granted. Expect m0 served first, then m1. Memory writes appear in order 0x020 then 0x024. Six cycles total.
- Fairness: both ports hold req continuously for 6 accesses. Expect grants to alternate 0,1,0,1,0,1, with never two consecutive grants to the same port.
- Misaligned: m1 requests LH addr 0x003, then LW addr 0x006. Expect m1_gnt with m1_rvalid and m1_err = 1 and m1_rdata = 0 for each. mem_read and mem_write never assert.
- Byte store then load: m0 does SB addr 0x041 data 0x000000A5, then LBU addr 0x041. Expect mem_funct3 = 000 then 100 and m0_rdata = 0x000000A5.
- Reset mid-access: assert reset during the ACCESS cycle of an m0 load. Expect all outputs 0 immediately, no m0_rvalid afterwards, and next contention granted to m0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core LSU (port 0)
// and the debug/loader DMA (port 1); misaligned accesses are answered without touching memory.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [DM_ADDRESS-1:0] m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [2:0]            m0_funct3,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [DM_ADDRESS-1:0] m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [2:0]            m1_funct3,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  m1_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_a,
  output logic [DATA_W-1:0]     mem_wd,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rd
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b001, 3'b101: misaligned = a[0];
      3'b010:         misaligned = (a != 2'b00);
      default:        misaligned = 1'b0;
    endcase
  endfunction

  state_t                r_state, w_state;
  logic                  r_last_grant, w_last_grant;
  logic                  r_id, w_id;
  logic                  r_we, w_we;
  logic [1:0]            r_gnt, w_gnt;
  logic [1:0]            r_rvalid, w_rvalid;
  logic [1:0]            r_err, w_err;
  logic [DATA_W-1:0]     r_rdata0, w_rdata0;
  logic [DATA_W-1:0]     r_rdata1, w_rdata1;
  logic                  r_mem_read, w_mem_read;
  logic                  r_mem_write, w_mem_write;
  logic [DM_ADDRESS-1:0] r_mem_a, w_mem_a;
  logic [DATA_W-1:0]     r_mem_wd, w_mem_wd;
  logic [2:0]            r_mem_funct3, w_mem_funct3;

  logic                  w_any;
  logic                  w_win;
  logic                  w_sel_we;
  logic [DM_ADDRESS-1:0] w_sel_addr;
  logic [DATA_W-1:0]     w_sel_wdata;
  logic [2:0]            w_sel_funct3;
  logic                  w_misal;
  logic [DATA_W-1:0]     w_resp_data;

  // Under contention the port that did not win last time is chosen.
  assign w_any        = m0_req | m1_req;
  assign w_win        = (m0_req && m1_req) ? ~r_last_grant : ~m0_req;
  assign w_sel_we     = w_win ? m1_we     : m0_we;
  assign w_sel_addr   = w_win ? m1_addr   : m0_addr;
  assign w_sel_wdata  = w_win ? m1_wdata  : m0_wdata;
  assign w_sel_funct3 = w_win ? m1_funct3 : m0_funct3;
  assign w_misal      = misaligned(w_sel_funct3, w_sel_addr[1:0]);
  assign w_resp_data  = r_we ? {DATA_W{1'b0}} : mem_rd;

  // Next-state and next-output computation for the arbitration FSM.
  always_comb begin
    w_state      = r_state;
    w_last_grant = r_last_grant;
    w_id         = r_id;
    w_we         = r_we;
    w_gnt        = 2'b00;
    w_rvalid     = 2'b00;
    w_err        = r_err;
    w_rdata0     = r_rdata0;
    w_rdata1     = r_rdata1;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_a      = {DM_ADDRESS{1'b0}};
    w_mem_wd     = {DATA_W{1'b0}};
    w_mem_funct3 = 3'b000;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_last_grant = w_win;
          w_id         = w_win;
          w_we         = w_sel_we;
          w_gnt[w_win] = 1'b1;
          if (w_misal) begin
            // Error path: grant, response and error together; memory stays idle.
            w_state         = ST_RESP;
            w_rvalid[w_win] = 1'b1;
            w_err[w_win]    = 1'b1;
            if (w_win) begin
              w_rdata1 = {DATA_W{1'b0}};
            end else begin
              w_rdata0 = {DATA_W{1'b0}};
            end
          end else begin
            w_state      = ST_ACCESS;
            w_mem_read   = ~w_sel_we;
            w_mem_write  = w_sel_we;
            w_mem_a      = w_sel_addr;
            w_mem_wd     = w_sel_wdata;
            w_mem_funct3 = w_sel_funct3;
          end
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        w_state        = ST_RESP;
        w_rvalid[r_id] = 1'b1;
        w_err[r_id]    = 1'b0;
        if (r_id) begin
          w_rdata1 = w_resp_data;
        end else begin
          w_rdata0 = w_resp_data;
        end
      end
      ST_RESP: begin
        w_state = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update; reset drops any in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_we         <= 1'b0;
      r_gnt        <= 2'b00;
      r_rvalid     <= 2'b00;
      r_err        <= 2'b00;
      r_rdata0     <= {DATA_W{1'b0}};
      r_rdata1     <= {DATA_W{1'b0}};
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_a      <= {DM_ADDRESS{1'b0}};
      r_mem_wd     <= {DATA_W{1'b0}};
      r_mem_funct3 <= 3'b000;
    end else begin
      r_state      <= w_state;
      r_last_grant <= w_last_grant;
      r_id         <= w_id;
      r_we         <= w_we;
      r_gnt        <= w_gnt;
      r_rvalid     <= w_rvalid;
      r_err        <= w_err;
      r_rdata0     <= w_rdata0;
      r_rdata1     <= w_rdata1;
      r_mem_read   <= w_mem_read;
      r_mem_write  <= w_mem_write;
      r_mem_a      <= w_mem_a;
      r_mem_wd     <= w_mem_wd;
      r_mem_funct3 <= w_mem_funct3;
    end
  end

  assign m0_gnt     = r_gnt[0];
  assign m1_gnt     = r_gnt[1];
  assign m0_rvalid  = r_rvalid[0];
  assign m1_rvalid  = r_rvalid[1];
  assign m0_err     = r_err[0];
  assign m1_err     = r_err[1];
  assign m0_rdata   = r_rdata0;
  assign m1_rdata   = r_rdata1;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_a      = r_mem_a;
  assign mem_wd     = r_mem_wd;
  assign mem_funct3 = r_mem_funct3;

endmodule
